snes_poll_scheduler: RTL

Autonomous poll sequencer for two SNES controller ports that share one latch line and one serial-clock line, with a separate data line per port. It generates the latch/shift timing at a programmable frame rate and deserialises both 16-bit button words. It also reports pad presence, and accumulates new button presses into a pending-event register handed to the CPU side via a valid/ack handshake. It replaces free-running single-pad capture as the front end feeding game logic.

---
 rtl/snes_poll_scheduler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/snes_poll_scheduler.sv
// rtl/snes_poll_scheduler.sv - Two-port SNES pad poll sequencer with presence detect and press-event capture
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 periodic polling every POLL_CYC cycles
//   force_poll             start a poll now if idle (ignored while polling)
//   data_p1, data_p2       asynchronous active-low serial data from each pad
//   latch, sclk            shared pad latch (active-high) and serial clock (idles high)
//   btn_p1, btn_p2         last complete button words, 1 = pressed, bit0 = first shifted
//   present_p1, present_p2 pad detected at last poll
//   frame_valid            high for the DONE cycle; btn/present/evt update at its end
//   evt_valid, evt_p1/2    accumulated new presses, held until evt_ack
//   evt_ack                consumer accepts the pending events
module snes_poll_scheduler #(
    parameter int LATCH_CYC = 600,
    parameter int HALF_CYC  = 300,
    parameter int POLL_CYC  = 833333
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        force_poll,
    input  logic        data_p1,
    input  logic        data_p2,
    output logic        latch,
    output logic        sclk,
    output logic [15:0] btn_p1,
    output logic [15:0] btn_p2,
    output logic        present_p1,
    output logic        present_p2,
    output logic        frame_valid,
    output logic        evt_valid,
    output logic [15:0] evt_p1,
    output logic [15:0] evt_p2,
    input  logic        evt_ack
);

    localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int TW     = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYC - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] ph_cnt, ph_cnt_nx;
    logic [3:0]    bit_idx, bit_idx_nx;
    logic [TW-1:0] timer;
    logic          start;
    logic          sample;

    logic          d1_m, d1_s, d2_m, d2_s;
    logic [15:0]   sr_p1, sr_p2;

    logic          pres1, pres2;
    logic [15:0]   word1, word2;
    logic [15:0]   press1, press2;
    logic          any_press;
    logic          ack_eff;

    // Pad data lines are asynchronous to clk; resync before sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_m <= 1'b1;
            d1_s <= 1'b1;
            d2_m <= 1'b1;
            d2_s <= 1'b1;
        end else begin
            d1_m <= data_p1;
            d1_s <= d1_m;
            d2_m <= data_p2;
            d2_s <= d2_m;
        end
    end

    always_comb begin
        state_nx   = state;
        ph_cnt_nx  = ph_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        start      = 1'b0;
        sample     = 1'b0;
        case (state)
            S_IDLE: begin
                ph_cnt_nx = '0;
                if (force_poll || (enable && (timer == POLL_LAST))) begin
                    start    = 1'b1;
                    state_nx = S_LATCH;
                end
            end
            S_LATCH: begin
                if (ph_cnt == LATCH_LAST) begin
                    state_nx  = S_GAP;
                    ph_cnt_nx = '0;
                end
            end
            S_GAP: begin
                if (ph_cnt == HALF_LAST) begin
                    state_nx   = S_LOW;
                    ph_cnt_nx  = '0;
                    bit_idx_nx = 4'd0;
                end
            end
            S_LOW: begin
                if (ph_cnt == HALF_LAST) begin
                    sample    = 1'b1;
                    state_nx  = S_HIGH;
                    ph_cnt_nx = '0;
                end
            end
            S_HIGH: begin
                if (ph_cnt == HALF_LAST) begin
                    ph_cnt_nx = '0;
                    if (bit_idx == 4'd15) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx   = S_LOW;
                        bit_idx_nx = bit_idx + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_nx  = S_IDLE;
                ph_cnt_nx = '0;
            end
            default: begin
                state_nx  = S_IDLE;
                ph_cnt_nx = '0;
            end
        endcase
    end

    // Pad-facing strobes are registered from the next state so they are
    // glitch-free yet line up exactly with the state they represent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            bit_idx     <= 4'd0;
            latch       <= 1'b0;
            sclk        <= 1'b1;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            ph_cnt      <= ph_cnt_nx;
            bit_idx     <= bit_idx_nx;
            latch       <= (state_nx == S_LATCH);
            sclk        <= (state_nx != S_LOW);
            frame_valid <= (state_nx == S_DONE);
        end
    end

    // Saturates so a long disabled stretch cannot wrap; the first enabled
    // cycle then starts a poll straight away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (start) begin
            timer <= '0;
        end else if (timer != POLL_LAST) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_p1 <= 16'h0000;
            sr_p2 <= 16'h0000;
        end else if (sample) begin
            sr_p1[bit_idx] <= ~d1_s;
            sr_p2[bit_idx] <= ~d2_s;
        end
    end

    // A real pad always returns released ID bits; an open line reads low,
    // which inverts to all ones and fails this check.
    assign pres1     = (sr_p1[15:12] == 4'b0000);
    assign pres2     = (sr_p2[15:12] == 4'b0000);
    assign word1     = pres1 ? sr_p1 : 16'h0000;
    assign word2     = pres2 ? sr_p2 : 16'h0000;
    assign press1    = word1 & ~btn_p1;
    assign press2    = word2 & ~btn_p2;
    assign any_press = |{press1, press2};
    assign ack_eff   = evt_ack && evt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_p1     <= 16'h0000;
            btn_p2     <= 16'h0000;
            present_p1 <= 1'b0;
            present_p2 <= 1'b0;
            evt_p1     <= 16'h0000;
            evt_p2     <= 16'h0000;
            evt_valid  <= 1'b0;
        end else if (state == S_DONE) begin
            btn_p1     <= word1;
            btn_p2     <= word2;
            present_p1 <= pres1;
            present_p2 <= pres2;
            // An ack landing on DONE retires only the old contents; this
            // frame's presses survive as the new pending set.
            if (ack_eff) begin
                evt_p1    <= press1;
                evt_p2    <= press2;
                evt_valid <= any_press;
            end else if (any_press) begin
                evt_p1    <= evt_p1 | press1;
                evt_p2    <= evt_p2 | press2;
                evt_valid <= 1'b1;
            end
        end else if (ack_eff) begin
            evt_p1    <= 16'h0000;
            evt_p2    <= 16'h0000;
            evt_valid <= 1'b0;
        end
    end

endmodule
